// File: rtl/ifu_fetch.sv
// Instruction fetch stage: takes one pc at a time, reads the instruction word
// over a single-beat AXI4-Lite read and hands {pc, inst, fault} to decode.
module ifu_fetch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  fault_q, fault_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      fault_q   <= fault_d;
    end
  end

  // A flush cannot cancel an AXI read already requested, so it is remembered
  // in discard_q and the response is drained and dropped when it arrives.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    fault_d   = fault_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          pc_d    = in_pc;
          state_d = AR;
        end
      end
      AR: begin
        if (flush)   discard_d = 1'b1;
        if (arready) state_d   = R;
      end
      R: begin
        if (flush) discard_d = 1'b1;
        if (rvalid) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            inst_d  = rdata;
            fault_d = (rresp != 2'b00);
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign arvalid   = (state_q == AR);
  assign rready    = (state_q == R);
  assign out_valid = (state_q == OUT) && !flush;
  assign araddr    = pc_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;
  assign out_fault = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by random
// traffic, compared each cycle against a transaction-level reference model.
module tb_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        flush;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: one fetch transaction and its progress through AXI.
  logic        mActive;
  logic [31:0] mPc;
  logic        mArDone;
  logic        mRDone;
  logic        mSquashed;
  logic [31:0] mInst;
  logic        mFault;

  ifu_fetch #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .flush(flush),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic checkOutput();
    chk("in_ready",  32'(in_ready),  32'(!mActive && !flush));
    chk("arvalid",   32'(arvalid),   32'(mActive && !mArDone));
    chk("rready",    32'(rready),    32'(mActive && mArDone && !mRDone));
    chk("out_valid", 32'(out_valid), 32'(mActive && mRDone && !flush));
    chk("araddr",    araddr,         mPc);
    chk("out_pc",    out_pc,         mPc);
    chk("out_inst",  out_inst,       mInst);
    chk("out_fault", 32'(out_fault), 32'(mFault));
  endtask

  task automatic updateModel();
    if (reset) begin
      mActive = 1'b0; mPc = '0; mInst = '0; mFault = 1'b0;
      mArDone = 1'b0; mRDone = 1'b0; mSquashed = 1'b0;
    end else if (!mActive) begin
      if (in_valid && !flush) begin
        mActive = 1'b1; mPc = in_pc;
        mArDone = 1'b0; mRDone = 1'b0; mSquashed = 1'b0;
      end
    end else if (!mArDone) begin
      if (flush)   mSquashed = 1'b1;
      if (arready) mArDone   = 1'b1;
    end else if (!mRDone) begin
      if (flush) mSquashed = 1'b1;
      if (rvalid) begin
        if (mSquashed) mActive = 1'b0;
        else begin
          mRDone = 1'b1; mInst = rdata; mFault = (rresp != 2'b00);
        end
      end
    end else if (flush || out_ready) begin
      mActive = 1'b0;
    end
  endtask

  task automatic cycle();
    #1;
    checkOutput();
    @(posedge clock);
    updateModel();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic fl,
                               input logic ar, input logic rv, input logic [31:0] rd,
                               input logic [1:0] rr, input logic ordy);
    in_valid = iv; in_pc = pc; flush = fl; arready = ar;
    rvalid = rv; rdata = rd; rresp = rr; out_ready = ordy;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_pc = '0; flush = 0; arready = 0;
    rvalid = 0; rdata = '0; rresp = 2'b00; out_ready = 0;
    mActive = 0; mPc = '0; mArDone = 0; mRDone = 0; mSquashed = 0; mInst = '0; mFault = 0;
    @(posedge clock);
    @(negedge clock);
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);
    reset = 1'b0;

    $display("[TB] basic fetch");
    applyStimulus(1, 32'h3000_0000, 0, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0, 2'b00, 0);
    chk("t1_araddr", araddr, 32'h3000_0000);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_0413, 2'b00, 0);
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_inst", out_inst, 32'h0000_0413);
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 1);

    $display("[TB] arready stall");
    applyStimulus(1, 32'h3000_0040, 0, 0, 0, 32'h0, 2'b00, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h3000_0999, 0, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h1111_2222, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 1);

    $display("[TB] flush in AR");
    applyStimulus(1, 32'h3000_0080, 0, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 1, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 2'b00, 1);
    applyStimulus(1, 32'h3000_0100, 0, 0, 0, 32'h0, 2'b00, 1);
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0010_0093, 2'b00, 0);
    #1;
    chk("t3_out_pc", out_pc, 32'h3000_0100);
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 1);

    $display("[TB] access fault");
    applyStimulus(1, 32'h3000_0200, 0, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0, 2'b10, 0);
    #1;
    chk("t4_out_fault", 32'(out_fault), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 1);

    $display("[TB] output stall then flush");
    applyStimulus(1, 32'h3000_0300, 0, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h1234_5678, 2'b00, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 1, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);

    $display("[TB] reset in R");
    applyStimulus(1, 32'h3000_0400, 0, 0, 0, 32'h0, 2'b00, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 32'h0, 2'b00, 0);
    reset = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);
    reset = 1'b0;
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 2'b00, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      logic rvRand;
      reset  = ($urandom_range(0, 199) == 0);
      rvRand = mActive && mArDone && !mRDone && ($urandom_range(0, 1) == 1);
      applyStimulus($urandom_range(0, 1) == 1, {$urandom_range(0, 32'h3FFF), 2'b00},
                    $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, rvRand,
                    $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
